// File: rtl/program_dumper_pkg.sv
// Shared widths and FSM state type for the memory read-back streamer.
package program_dumper_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int MEM_ADDR_SIZE = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } dumper_state_t;

endpackage

// File: rtl/program_dumper_if.sv
// Control, memory read port and output stream of the program dumper.
// The master modport is the dumper side; the slave modport is the memory/consumer side.
interface program_dumper_if;
  import program_dumper_pkg::*;

  logic                     start_dump;
  logic [MEM_ADDR_SIZE-1:0] dump_base;
  logic [MEM_ADDR_SIZE-1:0] dump_last;
  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic                     mem_read;
  logic [WORD_SIZE-1:0]     mem_read_data;
  logic [WORD_SIZE-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;
  logic                     dump_complete;

  modport master (
    input  start_dump, dump_base, dump_last, mem_read_data, out_ready,
    output mem_addr, mem_read, out_data, out_valid, out_last, busy, dump_complete
  );

  modport slave (
    output start_dump, dump_base, dump_last, mem_read_data, out_ready,
    input  mem_addr, mem_read, out_data, out_valid, out_last, busy, dump_complete
  );

endinterface

// File: rtl/program_dumper.sv
// Streams an inclusive, wrapping address range of memory out over valid/ready.
// One word costs READ, WAIT and SEND; every output comes straight from a register.
module program_dumper
  import program_dumper_pkg::*;
(
  input  logic clock,
  input  logic reset,
  program_dumper_if.master bus
);

  dumper_state_t            r_state;
  logic [MEM_ADDR_SIZE-1:0] r_memAddr;
  logic [MEM_ADDR_SIZE-1:0] r_lastQ;
  logic                     r_memRead;
  logic [WORD_SIZE-1:0]     r_outData;
  logic                     r_outValid;
  logic                     r_outLast;
  logic                     r_busy;
  logic                     r_dumpComplete;

  dumper_state_t            w_nextState;
  logic [MEM_ADDR_SIZE-1:0] w_nextMemAddr;
  logic [MEM_ADDR_SIZE-1:0] w_nextLastQ;
  logic                     w_nextMemRead;
  logic [WORD_SIZE-1:0]     w_nextOutData;
  logic                     w_nextOutValid;
  logic                     w_nextOutLast;
  logic                     w_nextDumpComplete;
  logic                     w_atLast;

  assign w_atLast = (r_memAddr == r_lastQ);

  // Reset drops every output at once, so an in-flight word is simply abandoned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_memAddr      <= '0;
      r_lastQ        <= '0;
      r_memRead      <= 1'b0;
      r_outData      <= '0;
      r_outValid     <= 1'b0;
      r_outLast      <= 1'b0;
      r_busy         <= 1'b0;
      r_dumpComplete <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_memAddr      <= w_nextMemAddr;
      r_lastQ        <= w_nextLastQ;
      r_memRead      <= w_nextMemRead;
      r_outData      <= w_nextOutData;
      r_outValid     <= w_nextOutValid;
      r_outLast      <= w_nextOutLast;
      r_busy         <= (w_nextState != S_IDLE) && (w_nextState != S_DONE);
      r_dumpComplete <= w_nextDumpComplete;
    end
  end

  always_comb begin
    w_nextState        = r_state;
    w_nextMemAddr      = r_memAddr;
    w_nextLastQ        = r_lastQ;
    w_nextMemRead      = r_memRead;
    w_nextOutData      = r_outData;
    w_nextOutValid     = r_outValid;
    w_nextOutLast      = r_outLast;
    w_nextDumpComplete = r_dumpComplete;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start_dump) begin
          w_nextLastQ        = bus.dump_last;
          w_nextMemAddr      = bus.dump_base;
          w_nextMemRead      = 1'b1;
          w_nextDumpComplete = 1'b0;
          w_nextState        = S_READ;
        end
      end
      S_READ: begin
        w_nextMemRead = 1'b0;
        w_nextState   = S_WAIT;
      end
      S_WAIT: begin
        w_nextOutData  = bus.mem_read_data;
        w_nextOutValid = 1'b1;
        w_nextOutLast  = w_atLast;
        w_nextState    = S_SEND;
      end
      S_SEND: begin
        // out_valid is always high here, so out_ready alone marks the transfer.
        if (bus.out_ready) begin
          w_nextOutValid = 1'b0;
          w_nextOutLast  = 1'b0;
          if (w_atLast) begin
            w_nextDumpComplete = 1'b1;
            w_nextState        = S_DONE;
          end else begin
            w_nextMemAddr = r_memAddr + 1'b1;
            w_nextMemRead = 1'b1;
            w_nextState   = S_READ;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign bus.mem_addr      = r_memAddr;
  assign bus.mem_read      = r_memRead;
  assign bus.out_data      = r_outData;
  assign bus.out_valid     = r_outValid;
  assign bus.out_last      = r_outLast;
  assign bus.busy          = r_busy;
  assign bus.dump_complete = r_dumpComplete;

endmodule

// File: tb/tb_program_dumper.sv
// Directed bench for program_dumper: a registered memory model feeds the DUT and a
// scoreboard of expected {word, last} pairs is drained on every stream transfer.
module tb_program_dumper;
  import program_dumper_pkg::*;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic                 last;
  } sbEntry_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   memReadCount;
  sbEntry_t scoreboard[$];
  logic [WORD_SIZE-1:0] mem [32];

  program_dumper_if bus();

  program_dumper dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory answers one cycle after the read strobe.
  always @(posedge clock) begin
    if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_addr];
  end

  function automatic logic [WORD_SIZE-1:0] memWord(input int addr);
    return 32'hA000_0000 + addr;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Transfers and read strobes are sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.mem_read) memReadCount++;
      if (bus.out_valid && bus.out_ready) begin
        if (scoreboard.size() == 0) begin
          checkOutput("unexpected_transfer", {31'b0, 1'b1}, 32'd0);
        end else begin
          sbEntry_t e;
          e = scoreboard.pop_front();
          checkOutput("out_data", bus.out_data, e.data);
          checkOutput("out_last", {31'b0, bus.out_last}, {31'b0, e.last});
        end
      end
    end
  end

  task automatic pushRange(input int base, input int last);
    int a;
    sbEntry_t e;
    a = base;
    forever begin
      e.data = memWord(a);
      e.last = (a == last);
      scoreboard.push_back(e);
      if (a == last) break;
      a = (a + 1) % 32;
    end
  endtask

  task automatic applyStimulus(input int base, input int last);
    bus.dump_base  = base[MEM_ADDR_SIZE-1:0];
    bus.dump_last  = last[MEM_ADDR_SIZE-1:0];
    bus.start_dump = 1'b1;
    @(posedge clock);
    #1;
    bus.start_dump = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    while (!bus.dump_complete && cycles < 400) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput(tag, {31'b0, bus.dump_complete}, 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_addr"},  {27'b0, bus.mem_addr}, 32'd0);
    checkOutput({tag, "_mem_read"},  {31'b0, bus.mem_read}, 32'd0);
    checkOutput({tag, "_out_data"},  bus.out_data, 32'd0);
    checkOutput({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    checkOutput({tag, "_out_last"},  {31'b0, bus.out_last}, 32'd0);
    checkOutput({tag, "_busy"},      {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, "_complete"},  {31'b0, bus.dump_complete}, 32'd0);
  endtask

  initial begin
    int cycles;
    int waitCount;
    checks       = 0;
    errors       = 0;
    memReadCount = 0;
    for (int i = 0; i < 32; i++) mem[i] = memWord(i);
    bus.start_dump    = 1'b0;
    bus.dump_base     = '0;
    bus.dump_last     = '0;
    bus.out_ready     = 1'b0;
    bus.mem_read_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Full 32-word dump with the consumer always ready.
    bus.out_ready = 1'b1;
    memReadCount  = 0;
    pushRange(0, 31);
    applyStimulus(0, 31);
    checkOutput("t1_mem_read_first", {31'b0, bus.mem_read}, 32'd1);
    checkOutput("t1_busy", {31'b0, bus.busy}, 32'd1);
    cycles = 0;
    while (!bus.dump_complete && cycles < 200) begin
      @(posedge clock);
      #1;
      cycles++;
      if (cycles == 1) checkOutput("t1_valid_early", {31'b0, bus.out_valid}, 32'd0);
      if (cycles == 2) checkOutput("t1_valid_latency", {31'b0, bus.out_valid}, 32'd1);
    end
    checkOutput("t1_total_cycles", cycles, 32'd96);
    checkOutput("t1_mem_reads", memReadCount, 32'd32);
    checkOutput("t1_scoreboard_empty", scoreboard.size(), 32'd0);
    checkOutput("t1_busy_done", {31'b0, bus.busy}, 32'd0);

    // Single-word range.
    memReadCount = 0;
    pushRange(7, 7);
    applyStimulus(7, 7);
    waitDone("t2_done", cycles);
    checkOutput("t2_mem_reads", memReadCount, 32'd1);
    checkOutput("t2_scoreboard_empty", scoreboard.size(), 32'd0);

    // Wrapping range.
    pushRange(30, 1);
    applyStimulus(30, 1);
    waitDone("t3_done", cycles);
    checkOutput("t3_scoreboard_empty", scoreboard.size(), 32'd0);

    // Back-pressure on the second word.
    memReadCount = 0;
    pushRange(0, 3);
    applyStimulus(0, 3);
    waitCount = 0;
    while (!(scoreboard.size() == 3 && !bus.out_valid) && waitCount < 50) begin
      @(posedge clock);
      #1;
      waitCount++;
    end
    bus.out_ready = 1'b0;
    waitCount = 0;
    while (!bus.out_valid && waitCount < 50) begin
      @(posedge clock);
      #1;
      waitCount++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_stall_valid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("t4_stall_data", bus.out_data, memWord(1));
      checkOutput("t4_stall_no_read", {31'b0, bus.mem_read}, 32'd0);
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    waitDone("t4_done", cycles);
    checkOutput("t4_mem_reads", memReadCount, 32'd4);
    checkOutput("t4_scoreboard_empty", scoreboard.size(), 32'd0);

    // Reset while the fifth word waits in SEND.
    pushRange(0, 9);
    applyStimulus(0, 9);
    waitCount = 0;
    while (!(scoreboard.size() == 6 && !bus.out_valid) && waitCount < 100) begin
      @(posedge clock);
      #1;
      waitCount++;
    end
    bus.out_ready = 1'b0;
    waitCount = 0;
    while (!bus.out_valid && waitCount < 50) begin
      @(posedge clock);
      #1;
      waitCount++;
    end
    checkOutput("t5_in_send", {31'b0, bus.out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("t5_async_reset");
    scoreboard.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("t5_no_stale_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    pushRange(12, 13);
    applyStimulus(12, 13);
    checkOutput("t5_new_base", {27'b0, bus.mem_addr}, 32'd12);
    waitDone("t5_done", cycles);
    checkOutput("t5_scoreboard_empty", scoreboard.size(), 32'd0);

    // Start while busy is ignored; start in DONE re-dumps.
    pushRange(20, 23);
    applyStimulus(20, 23);
    repeat (4) @(posedge clock);
    #1;
    applyStimulus(5, 5);
    waitDone("t6_done", cycles);
    checkOutput("t6_scoreboard_empty", scoreboard.size(), 32'd0);
    pushRange(20, 23);
    applyStimulus(20, 23);
    checkOutput("t6_complete_cleared", {31'b0, bus.dump_complete}, 32'd0);
    checkOutput("t6_restart_addr", {27'b0, bus.mem_addr}, 32'd20);
    waitDone("t6_redump_done", cycles);
    checkOutput("t6_redump_empty", scoreboard.size(), 32'd0);

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
